// File: rtl/cache_axi_bridge.sv
// Bridges the cache rd/ret/wr request interface onto one AXI master port.
// Each accepted request becomes one AXI burst. At most one read and one write can be outstanding.
module cache_axi_bridge #(
  parameter int         LINE_WIDTH = 256,
  parameter int         BEAT_CNT_W = 3,
  parameter logic [3:0] AXI_RD_ID  = 4'd0,
  parameter logic [3:0] AXI_WR_ID  = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_req,
  input  logic [2:0]            rd_type,
  input  logic [31:0]           rd_addr,
  output logic                  rd_rdy,
  output logic                  ret_valid,
  output logic                  ret_last,
  output logic [31:0]           ret_data,
  input  logic                  wr_req,
  input  logic [2:0]            wr_type,
  input  logic [31:0]           wr_addr,
  input  logic [3:0]            wr_wstrb,
  input  logic [LINE_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int         LINE_BEATS = LINE_WIDTH / 32;
  localparam logic [7:0] LINE_LEN   = 8'(LINE_BEATS - 1);
  localparam logic [2:0] TYPE_LINE  = 3'b100;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_e;

  rd_state_e             rd_state_q;
  logic [31:0]           rd_addr_q;
  logic                  rd_line_q;
  wr_state_e             wr_state_q;
  logic [31:0]           wr_addr_q;
  logic                  wr_line_q;
  logic [3:0]            wr_strb_q;
  logic [LINE_WIDTH-1:0] wr_buf_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic                  unused_s;

  // Response ids/status are not used: only one burst per direction is ever in flight.
  assign unused_s = ^{rid, rresp, bid, bresp};

  // A pending write (current or same-cycle) blocks read acceptance so reads never pass writes.
  assign rd_rdy = (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE) && !wr_req;
  assign wr_rdy = (wr_state_q == W_IDLE);

  assign arid    = AXI_RD_ID;
  assign araddr  = rd_addr_q;
  assign arlen   = rd_line_q ? LINE_LEN : 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (rd_state_q == R_AR);
  assign rready  = (rd_state_q == R_DATA);

  // Returned beats pass straight through so the cache sees data with no added latency.
  assign ret_valid = rready & rvalid;
  assign ret_last  = rready & rvalid & rlast;
  assign ret_data  = rdata;

  assign awid    = AXI_WR_ID;
  assign awaddr  = wr_addr_q;
  assign awlen   = wr_line_q ? LINE_LEN : 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (wr_state_q == W_AW);
  assign wvalid  = (wr_state_q == W_DATA);
  assign wdata   = wr_buf_q[31:0];
  assign wstrb   = wr_line_q ? 4'hf : wr_strb_q;
  assign wlast   = (wr_state_q == W_DATA) && (8'(beat_cnt_q) == awlen);
  assign bready  = (wr_state_q == W_RESP);

  // Read request FSM: latch request, issue AR, then pass R beats through until rlast.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= 32'd0;
      rd_line_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            rd_addr_q  <= rd_addr;
            rd_line_q  <= (rd_type == TYPE_LINE);
            rd_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) rd_state_q <= R_DATA;
        end
        R_DATA: begin
          if (rvalid && rlast) rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write request FSM: AW first, then shift the line buffer out one beat per W handshake, then B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= 32'd0;
      wr_line_q  <= 1'b0;
      wr_strb_q  <= 4'h0;
      wr_buf_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (wr_req) begin
            wr_addr_q  <= wr_addr;
            wr_line_q  <= (wr_type == TYPE_LINE);
            wr_strb_q  <= wr_wstrb;
            wr_buf_q   <= wr_data;
            beat_cnt_q <= '0;
            wr_state_q <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            beat_cnt_q <= '0;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready) begin
            wr_buf_q   <= wr_buf_q >> 32;
            beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
            if (wlast) wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

endmodule
